// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES-128 constants, round constants and key-schedule FSM states
package aes_pkg;

    localparam int NR = 10;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_EMIT = 1'b1
    } ks_state_t;

    // Rcon[1..10]; indices outside that range never feed a real step
    function automatic logic [7:0] rcon(input logic [3:0] r);
        logic [7:0] v;
        v = 8'h00;
        case (r)
            4'd1:    v = 8'h01;
            4'd2:    v = 8'h02;
            4'd3:    v = 8'h04;
            4'd4:    v = 8'h08;
            4'd5:    v = 8'h10;
            4'd6:    v = 8'h20;
            4'd7:    v = 8'h40;
            4'd8:    v = 8'h80;
            4'd9:    v = 8'h1b;
            4'd10:   v = 8'h36;
            default: v = 8'h00;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/sbox.sv
// rtl/sbox.sv - combinational AES forward S-box, shared with the SubBytes stage
module sbox (
    input  logic [7:0] i_byte,
    output logic [7:0] o_byte
);

    // Row r holds S[r*16 + 0] in its top byte down to S[r*16 + 15] in its bottom byte
    localparam logic [127:0] SBOX_ROW [16] = '{
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    logic [127:0] w_row;

    always_comb begin
        w_row  = SBOX_ROW[i_byte[7:4]];
        o_byte = w_row[(4'd15 - i_byte[3:0]) * 8 +: 8];
    end

endmodule

// File: rtl/round_key_gen.sv
// rtl/round_key_gen.sv - on-the-fly AES-128 round key generator, forward or reverse order
module round_key_gen
    import aes_pkg::*;
#(
    parameter int NR = aes_pkg::NR
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         decrypt,
    input  logic [127:0] key_in,
    input  logic         rk_ready,
    output logic         rk_valid,
    output logic [127:0] rk_out,
    output logic [3:0]   rk_index,
    output logic         busy,
    output logic         done
);

    localparam logic [3:0] LAST_IDX = 4'(NR);

    ks_state_t    r_state;
    ks_state_t    w_state_nxt;
    logic [127:0] r_key;
    logic [3:0]   r_idx;
    logic         r_dec;
    logic         r_done;

    logic         w_accept;
    logic         w_last;
    logic         w_load;
    logic         w_step;

    logic [31:0]  w_w0, w_w1, w_w2, w_w3;
    logic [31:0]  w_rev3, w_rev2, w_rev1;
    logic [31:0]  w_sub_in, w_rot, w_sub;
    logic [7:0]   w_rcon;
    logic [31:0]  w_t;
    logic [31:0]  w_f0, w_f1, w_f2, w_f3;
    logic [127:0] w_key_nxt;

    assign {w_w0, w_w1, w_w2, w_w3} = r_key;

    // Reverse step recovers w3..w1 by XOR alone; only w0 needs SubWord, of the recovered w3
    assign w_rev3   = w_w3 ^ w_w2;
    assign w_rev2   = w_w2 ^ w_w1;
    assign w_rev1   = w_w1 ^ w_w0;
    assign w_sub_in = r_dec ? w_rev3 : w_w3;
    assign w_rot    = {w_sub_in[23:0], w_sub_in[31:24]};
    assign w_rcon   = rcon(r_dec ? r_idx : r_idx + 4'd1);

    genvar g;
    generate
        for (g = 0; g < 4; g++) begin : g_subword
            sbox u_sbox (
                .i_byte (w_rot[g*8 +: 8]),
                .o_byte (w_sub[g*8 +: 8])
            );
        end
    endgenerate

    assign w_t  = w_sub ^ {w_rcon, 24'h0};
    assign w_f0 = w_w0 ^ w_t;
    assign w_f1 = w_w1 ^ w_f0;
    assign w_f2 = w_w2 ^ w_f1;
    assign w_f3 = w_w3 ^ w_f2;

    assign w_key_nxt = r_dec ? {w_t ^ w_w0, w_rev1, w_rev2, w_rev3}
                             : {w_f0, w_f1, w_f2, w_f3};

    assign w_accept = (r_state == ST_EMIT) && rk_ready;
    assign w_last   = r_dec ? (r_idx == 4'd0) : (r_idx == LAST_IDX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_step      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_load      = 1'b1;
                    w_state_nxt = ST_EMIT;
                end
            end
            ST_EMIT: begin
                if (w_accept) begin
                    if (w_last) begin
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_step = 1'b1;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_key  <= '0;
            r_idx  <= '0;
            r_dec  <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_done <= w_accept && w_last;
            if (w_load) begin
                r_key <= key_in;
                r_idx <= decrypt ? LAST_IDX : 4'd0;
                r_dec <= decrypt;
            end else if (w_step) begin
                r_key <= w_key_nxt;
                r_idx <= r_dec ? r_idx - 4'd1 : r_idx + 4'd1;
            end
        end
    end

    assign rk_valid = (r_state == ST_EMIT);
    assign busy     = (r_state != ST_IDLE);
    assign rk_out   = r_key;
    assign rk_index = r_idx;
    assign done     = r_done;

endmodule

// File: tb/tb_round_key_gen.sv
// tb/tb_round_key_gen.sv - scoreboard bench for round_key_gen against the FIPS-197 A.1 schedule
module tb_round_key_gen;

    typedef struct {
        logic [3:0]   idx;
        logic [127:0] key;
    } exp_t;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic         decrypt;
    logic [127:0] key_in;
    logic         rk_ready;
    logic         rk_valid;
    logic [127:0] rk_out;
    logic [3:0]   rk_index;
    logic         busy;
    logic         done;

    int           n_tests;
    int           n_fail;
    int           done_cnt;
    exp_t         sb_q[$];
    logic [127:0] ref_keys [0:10];

    logic         mon_stalled;
    logic [127:0] mon_key;
    logic [3:0]   mon_idx;

    round_key_gen #(.NR(10)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .decrypt  (decrypt),
        .key_in   (key_in),
        .rk_ready (rk_ready),
        .rk_valid (rk_valid),
        .rk_out   (rk_out),
        .rk_index (rk_index),
        .busy     (busy),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Monitor: compare every accepted key with the scoreboard, and hold-stability during stalls
    always @(negedge clk) begin
        if (done) done_cnt++;
        if (!rst_n || !rk_valid) begin
            mon_stalled = 1'b0;
        end else begin
            if (mon_stalled) begin
                check("stall_key", rk_out, mon_key);
                check("stall_idx", 128'(rk_index), 128'(mon_idx));
            end
            if (rk_ready) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_key", 128'(1), 128'(0));
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check("idx", 128'(rk_index), 128'(e.idx));
                    check("key", rk_out, e.key);
                end
            end
            mon_stalled = !rk_ready;
            mon_key     = rk_out;
            mon_idx     = rk_index;
        end
    end

    task automatic begin_sched(input logic dec, input logic [127:0] key);
        exp_t e;
        for (int i = 0; i <= 10; i++) begin
            e.idx = dec ? 4'(10 - i) : 4'(i);
            e.key = ref_keys[e.idx];
            sb_q.push_back(e);
        end
        start   = 1'b1;
        decrypt = dec;
        key_in  = key;
        @(posedge clk);
        #1;
        start   = 1'b0;
        key_in  = '0;
    endtask

    task automatic wait_done(input int stall_at, input int poke_at, input int exp_cycles);
        int cycles;
        int stall_cnt;
        bit stalled;
        bit poked;
        bit poke_clr;
        cycles = 0; stall_cnt = 0; stalled = 0; poked = 0; poke_clr = 0;
        check("busy_run", 128'(busy), 128'(1));
        while (cycles < 40) begin
            @(posedge clk);
            #1;
            cycles++;
            if (poke_clr) begin
                start = 1'b0;
                poke_clr = 0;
            end
            if (done) break;
            if (stall_cnt > 0) begin
                stall_cnt--;
                if (stall_cnt == 0) rk_ready = 1'b1;
            end
            if (!stalled && rk_valid && int'(rk_index) == stall_at) begin
                rk_ready  = 1'b0;
                stall_cnt = 3;
                stalled   = 1;
            end
            if (!poked && rk_valid && int'(rk_index) == poke_at) begin
                start    = 1'b1;
                decrypt  = ~decrypt;
                key_in   = {$urandom, $urandom, $urandom, $urandom};
                poked    = 1;
                poke_clr = 1;
            end
        end
        start    = 1'b0;
        rk_ready = 1'b1;
        check("done_seen", 128'(done), 128'(1));
        check("cycles_to_done", 128'(cycles), 128'(exp_cycles));
        check("valid_at_done", 128'(rk_valid), 128'(0));
        check("busy_at_done", 128'(busy), 128'(0));
        check("sb_drained", 128'(sb_q.size()), 128'(0));
    endtask

    initial begin
        int guard;
        int done_snap;
        n_tests = 0; n_fail = 0; done_cnt = 0;
        mon_stalled = 1'b0; mon_key = '0; mon_idx = '0;
        ref_keys[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        ref_keys[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
        ref_keys[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
        ref_keys[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
        ref_keys[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
        ref_keys[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
        ref_keys[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
        ref_keys[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
        ref_keys[8]  = 128'head27321b58dbad2312bf5607f8d292f;
        ref_keys[9]  = 128'hac7766f319fadc2128d12941575c006e;
        ref_keys[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

        rst_n = 1'b0; start = 1'b0; decrypt = 1'b0; key_in = '0; rk_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", 128'(rk_valid), 128'(0));
        check("rst_busy", 128'(busy), 128'(0));
        check("rst_done", 128'(done), 128'(0));
        check("rst_key", rk_out, 128'(0));
        check("rst_idx", 128'(rk_index), 128'(0));
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // forward schedule, then confirm done lasts one cycle
        begin_sched(1'b0, ref_keys[0]);
        check("valid_after_start", 128'(rk_valid), 128'(1));
        wait_done(-1, -1, 11);
        @(posedge clk);
        #1;
        check("done_one_cycle", 128'(done), 128'(0));

        // reverse schedule seeded with the round-10 key
        begin_sched(1'b1, ref_keys[10]);
        wait_done(-1, -1, 11);

        // three-cycle backpressure on index 4
        begin_sched(1'b0, ref_keys[0]);
        wait_done(4, -1, 14);

        // start with a different key while busy at index 6
        begin_sched(1'b0, ref_keys[0]);
        wait_done(-1, 6, 11);

        // reset in the middle of the schedule at index 5
        begin_sched(1'b0, ref_keys[0]);
        guard = 0;
        while (!(rk_valid && rk_index == 4'd5) && guard < 40) begin
            @(posedge clk);
            #1;
            guard++;
        end
        check("reach_idx5", 128'(rk_index), 128'(5));
        done_snap = done_cnt;
        rst_n = 1'b0;
        #1;
        check("abort_valid", 128'(rk_valid), 128'(0));
        check("abort_busy", 128'(busy), 128'(0));
        sb_q.delete();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("abort_no_done", 128'(done_cnt), 128'(done_snap));
        check("idle_after_release", 128'(rk_valid), 128'(0));
        begin_sched(1'b0, ref_keys[0]);
        wait_done(-1, -1, 11);

        // start in the done cycle is honoured
        begin_sched(1'b0, ref_keys[0]);
        check("restart_valid", 128'(rk_valid), 128'(1));
        check("restart_idx", 128'(rk_index), 128'(0));
        wait_done(-1, -1, 11);

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
        $fatal(1);
    end

endmodule

// File: doc/round_key_gen.md
ROUND_KEY_GEN -- requirements
Module: round_key_gen

Interface
REQ-001 The block SHALL take parameter NR, default 10, meaning the number of AES-128 rounds; only 10 is supported.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, the reset: asynchronous and active-low.
REQ-004 The block SHALL have port start, input, 1, the request to begin a schedule; sampled only in IDLE.
REQ-005 The block SHALL have port decrypt, input, 1, the order select sampled with start: 0 gives round 0..10, 1 gives round 10..0.
REQ-006 The block SHALL have port key_in, input, 128, the seed key sampled with start: the cipher key if decrypt=0, the round-10 key if decrypt=1.
REQ-007 The block SHALL have port rk_ready, input, 1, the consumer (AddRoundKey stage) accepting rk_out.
REQ-008 The block SHALL have port rk_valid, output, 1, meaning rk_out/rk_index are valid.
REQ-009 The block SHALL have port rk_out, output, 128, the current round key with word 0 in bits [127:96].
REQ-010 The block SHALL have port rk_index, output, 4, the round number of rk_out (0..10).
REQ-011 The block SHALL have port busy, output, 1, high in every state except IDLE.
REQ-012 The block SHALL have port done, output, 1, a one-cycle pulse after the final key is accepted.

Function
REQ-013 The FSM SHALL have states IDLE and EMIT.
- IDLE -> EMIT on start.
- EMIT -> EMIT on each accepted non-final key.
- EMIT -> IDLE when the final key is accepted.
REQ-014 When start is high in IDLE at edge N, the block SHALL load key_in into the key register and set rk_index to 0 (decrypt=0) or 10 (decrypt=1); rk_valid SHALL be high from cycle N+1.
REQ-015 A key SHALL be accepted only on an edge where rk_valid and rk_ready are both high.
REQ-016 While rk_valid is high and rk_ready is low, rk_out and rk_index SHALL hold stable.
REQ-017 With rk_ready held high, the block SHALL emit one key per cycle, giving 11 keys in 11 consecutive cycles.
REQ-018 Forward step (r -> r+1), with w0..w3 the current key:
- t = SubWord(RotWord(w3)) xor {Rcon[r+1],24'h0}
- next keys: w0'=w0^t, w1'=w1^w0', w2'=w2^w1', w3'=w3^w2'.
REQ-019 Reverse step (r -> r-1):
- w3'=w3^w2, w2'=w2^w1, w1'=w1^w0
- w0'=w0 ^ SubWord(RotWord(w3')) ^ {Rcon[r],24'h0}.
REQ-020 Rcon[1..10] SHALL be 01,02,04,08,10,20,40,80,1B,36.
REQ-021 Final index SHALL be 10 forward and 0 reverse; on its acceptance:
- done SHALL pulse high for exactly the next cycle
- rk_valid SHALL drop in that same cycle
- rk_index SHALL not wrap.
REQ-022 start asserted while busy SHALL be ignored, with no effect on the key, index or order.
REQ-023 start in the same cycle that done is high SHALL be honoured, because the FSM is already in IDLE.

Reset
REQ-024 While rst_n is low, the outputs SHALL be: rk_valid=0, busy=0, done=0, rk_out=0, rk_index=0, FSM=IDLE.
REQ-025 Reset asserted mid-schedule SHALL abort the schedule immediately with no done pulse; after release the block SHALL require a new start.

Structure
REQ-026 The shared package aes_pkg SHALL hold NR, the Rcon table and the FSM state typedef.
REQ-027 The block SHALL instantiate the existing combinational sub-module sbox (the forward S-box shared with SubBytes) four times for SubWord; no inverse S-box is needed.
REQ-028 Next-key logic SHALL be combinational from the key register; the only registers SHALL be key, index, order, FSM state and done.

Verification
Key K = 2b7e1516_28aed2a6_abf71588_09cf4f3c.
REQ-029 Forward run, K, ready=1: indices 0..10 in 11 consecutive cycles; idx1=a0fafe17_88542cb1_23a33939_2a6c7605; idx10=d014f9a8_c9ee2589_e13f0cc8_b6630ca6; done one cycle later.
REQ-030 Reverse run, key_in = round-10 key above, decrypt=1: first output idx10 = that key, idx1 = a0fafe17..., idx0 = K, then done.
REQ-031 Backpressure: ready low for 3 cycles at idx4 -> rk_out/rk_index stable for those 3 cycles, and the next key appears one cycle after ready returns high.
REQ-032 start pulsed at idx6 with a different key_in -> sequence unchanged, all keys still match the K schedule.
REQ-033 rst_n low at idx5 -> rk_valid=0 and busy=0 asynchronously, no done; a new start then reproduces REQ-029 exactly.
REQ-034 start asserted in the done cycle -> new schedule begins, with rk_valid high on the following cycle.
